// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and status signals of the single-port
// memory arbiter. Also defines the memory command encoding shared by all users.
`ifndef MEM_PORT_ARBITER_CMD_DEFS
`define MEM_PORT_ARBITER_CMD_DEFS
`define W_MEM_CMD 2
`define MEM_NOP   2'b00
`define MEM_READ  2'b01
`define MEM_WRITE 2'b10
`endif

interface mem_port_arbiter_if #(
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_DATA = 32
);
  // fetch requester
  logic                  if_req;
  logic [W_ADDR-1:0]     if_addr;
  logic                  if_ack;
  logic [W_DATA-1:0]     if_rdata;
  // data requester
  logic                  dm_req;
  logic [`W_MEM_CMD-1:0] dm_cmd;
  logic [W_ADDR-1:0]     dm_addr;
  logic [W_DATA-1:0]     dm_wdata;
  logic                  dm_ack;
  logic [W_DATA-1:0]     dm_rdata;
  // memory side
  logic [`W_MEM_CMD-1:0] mem_cmd;
  logic [W_ADDR-1:0]     mem_addr;
  logic [W_DATA-1:0]     mem_wdata;
  logic [W_DATA-1:0]     mem_rdata;
  // status
  logic                  busy;
  logic                  stall;

  // arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_cmd, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_cmd, mem_addr, mem_wdata,
           busy, stall
  );

  // requesters + memory model side
  modport master (
    output if_req, if_addr, dm_req, dm_cmd, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_cmd, mem_addr, mem_wdata,
           busy, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data
// load/store. Data has priority; the command is held for MEM_LAT cycles, then
// the winner gets a one-cycle ack. Optional fetch starvation guard is enabled
// by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned W_ADDR   = 32,
  parameter int unsigned W_DATA   = 32,
  parameter int unsigned MEM_LAT  = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned W_CNT = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [W_CNT-1:0]      cnt_q, cnt_d;
  logic                  win_dm_q, win_dm_d;
  logic [`W_MEM_CMD-1:0] cmd_q, cmd_d;
  logic [W_ADDR-1:0]     addr_q, addr_d;
  logic [W_DATA-1:0]     wdata_q, wdata_d;
  logic [W_DATA-1:0]     if_rdata_q, if_rdata_d;
  logic [W_DATA-1:0]     dm_rdata_q, dm_rdata_d;

  logic dm_valid;
  logic grant_dm;
  logic grant_if;
  logic granting;
  logic force_if;
  logic if_ack;
  logic dm_ack;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned W_STV = $clog2(MAX_WAIT + 1);

  logic [W_STV-1:0] stv_q, stv_d;

  // fetch is forced once data has won MAX_WAIT grants in a row against it
  assign force_if = bus.if_req && (stv_q == W_STV'(MAX_WAIT));

  // starvation counter: counts data grants that left fetch waiting, saturating
  always_comb begin
    stv_d = stv_q;
    if (granting) begin
      if (grant_if || !bus.if_req) begin
        stv_d = '0;
      end else if (stv_q != W_STV'(MAX_WAIT)) begin
        stv_d = stv_q + W_STV'(1);
      end
    end
  end

  // starvation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stv_q <= '0;
    end else begin
      stv_q <= stv_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // arbitration: a data request with a NOP command does not count
  always_comb begin
    dm_valid = bus.dm_req && (bus.dm_cmd != `MEM_NOP);
    grant_dm = dm_valid && !force_if;
    grant_if = bus.if_req && !grant_dm;
    granting = (state_q == ST_IDLE) && (grant_dm || grant_if);
  end

  // next-state: grant in IDLE, hold the command MEM_LAT cycles, ack in RESP
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_dm_d   = win_dm_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (granting) begin
          state_d  = ST_BUSY;
          cnt_d    = W_CNT'(MEM_LAT - 1);
          win_dm_d = grant_dm;
          cmd_d    = grant_dm ? bus.dm_cmd   : `MEM_READ;
          addr_d   = grant_dm ? bus.dm_addr  : bus.if_addr;
          wdata_d  = grant_dm ? bus.dm_wdata : wdata_q;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          if (cmd_q == `MEM_READ) begin
            if (win_dm_q) begin
              dm_rdata_d = bus.mem_rdata;
            end else begin
              if_rdata_d = bus.mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - W_CNT'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and access registers; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      win_dm_q   <= 1'b0;
      cmd_q      <= `MEM_NOP;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_dm_q   <= win_dm_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // outputs decoded from state so an async reset silences the port at once
  always_comb begin
    if_ack = (state_q == ST_RESP) && !win_dm_q;
    dm_ack = (state_q == ST_RESP) &&  win_dm_q;
  end

  assign bus.if_ack    = if_ack;
  assign bus.dm_ack    = dm_ack;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_cmd   = (state_q == ST_BUSY) ? cmd_q : `MEM_NOP;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q == ST_BUSY) || (state_q == ST_RESP);
  assign bus.stall     = !rst && ((bus.if_req && !if_ack) || (bus.dm_req && !dm_ack));

endmodule
